// File: rtl/exec_pkg.sv
// Shared definitions for seq_exec_unit: op codes, FSM states, NZP flag bit positions.
package exec_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_AND  = 3'b001,
    OP_NOT  = 3'b010,
    OP_PASS = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_SRA  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned NZP_N = 2;
  localparam int unsigned NZP_Z = 1;
  localparam int unsigned NZP_P = 0;

endpackage

// File: rtl/ripple_adder_n.sv
// W-bit ripple-carry adder with carry in and carry out.
module ripple_adder_n #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  always_comb begin
    logic c;
    sum_o = '0;
    c     = cin_i;
    for (int i = 0; i < int'(W); i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end

endmodule

// File: rtl/seq_exec_unit.sv
// Multi-cycle ALU with valid/ready handshake on both sides.
// The bit-serial shifter is built only when EXEC_SHIFT_EN is defined.
module seq_exec_unit
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IMM_W  = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [IMM_W-1:0]  imm,
  input  logic              use_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        nzp,
  output logic              cout
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [2:0]        nzp_q, nzp_d;
  logic              cout_q, cout_d;
  logic [DATA_W-1:0] b_eff, alu_res, sum;
  logic              add_cout, accept;
  op_e               op_in;

  function automatic logic [2:0] nzp_of(input logic [DATA_W-1:0] v);
    logic [2:0] f;
    f = '0;
    if (v[DATA_W-1])   f[NZP_N] = 1'b1;
    else if (v == '0)  f[NZP_Z] = 1'b1;
    else               f[NZP_P] = 1'b1;
    return f;
  endfunction

  assign op_in  = op_e'(op);
  assign b_eff  = use_imm ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm} : b;
  assign accept = in_valid & in_ready;

  ripple_adder_n #(.W(DATA_W)) u_add (
    .a_i   (a),
    .b_i   (b_eff),
    .cin_i (1'b0),
    .sum_o (sum),
    .cout_o(add_cout)
  );

  // Single-cycle result; shift ops land here only with k=0 (or when the shifter is absent)
  always_comb begin
    alu_res = a;
    case (op_in)
      OP_ADD:  alu_res = sum;
      OP_AND:  alu_res = a & b_eff;
      OP_NOT:  alu_res = ~a;
      default: alu_res = a;
    endcase
  end

`ifdef EXEC_SHIFT_EN
  op_e             sh_op_q, sh_op_d;
  logic [SH_W-1:0] cnt_q, cnt_d;
  logic [SH_W-1:0] k;
  logic            is_shift;

  assign k        = b_eff[SH_W-1:0];
  assign is_shift = (op_in == OP_SHL) || (op_in == OP_SHR) || (op_in == OP_SRA);

  function automatic logic [DATA_W-1:0] shift1(input op_e o, input logic [DATA_W-1:0] v);
    case (o)
      OP_SHL:  return {v[DATA_W-2:0], 1'b0};
      OP_SHR:  return {1'b0, v[DATA_W-1:1]};
      default: return {v[DATA_W-1], v[DATA_W-1:1]};
    endcase
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    nzp_d    = nzp_q;
    cout_d   = cout_q;
`ifdef EXEC_SHIFT_EN
    sh_op_d  = sh_op_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_DONE: if (out_ready) state_d = ST_IDLE;
`ifdef EXEC_SHIFT_EN
      // result_q doubles as the shift register while out_valid is low
      ST_SHIFT: begin
        result_d = shift1(sh_op_q, result_q);
        if (cnt_q == SH_W'(1)) begin
          state_d = ST_DONE;
          nzp_d   = nzp_of(result_d);
        end else begin
          cnt_d = cnt_q - SH_W'(1);
        end
      end
`endif
      default: ;
    endcase

    if (accept) begin
      state_d  = ST_DONE;
      result_d = alu_res;
      nzp_d    = nzp_of(alu_res);
      cout_d   = (op_in == OP_ADD) ? add_cout : 1'b0;
`ifdef EXEC_SHIFT_EN
      if (is_shift && (k != '0)) begin
        state_d  = ST_SHIFT;
        result_d = a;
        sh_op_d  = op_in;
        cnt_d    = k;
      end
`endif
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      nzp_q    <= 3'b010;
      cout_q   <= 1'b0;
`ifdef EXEC_SHIFT_EN
      sh_op_q  <= OP_ADD;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      nzp_q    <= nzp_d;
      cout_q   <= cout_d;
`ifdef EXEC_SHIFT_EN
      sh_op_q  <= sh_op_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign nzp       = nzp_q;
  assign cout      = cout_q;

endmodule

// File: doc/seq_exec_unit.md
SEQ_EXEC_UNIT -- requirements
Module: seq_exec_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16: operand/result width, >= 8.
REQ-002 SHALL have parameter IMM_W, default 5: immediate field width, < DATA_W.
REQ-003 SHALL have port Clk, input, 1: the only clock; every register is rising-edge.
REQ-004 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operation offered.
REQ-006 SHALL have port in_ready, output, 1: unit accepts an operation this cycle.
REQ-007 SHALL have port op, input, 3: operation code; encodings per REQ-014.
REQ-008 SHALL have ports a and b, input, DATA_W each: source operands.
REQ-009 SHALL have ports imm (input, IMM_W) and use_imm (input, 1): when use_imm=1, B operand = sign-extended imm.
REQ-010 SHALL have port out_valid, output, 1: result held.
REQ-011 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-012 SHALL have ports result (output, DATA_W), nzp (output, 3, {N,Z,P}) and cout (output, 1, ADD carry).

Function
REQ-013 SHALL capture op, a and the effective B on an accept (in_valid & in_ready); later input changes do not affect that operation.
REQ-014 SHALL use op codes 000 ADD (a+B mod 2^DATA_W), 001 AND, 010 NOT a, 011 PASS a, 100 SHL, 101 SHR logical, 110 SRA, 111 reserved (acts as PASS a).
REQ-015 SHALL take the shift amount k from B[$clog2(DATA_W)-1:0], unsigned.
REQ-016 SHALL implement FSM states IDLE, SHIFT and DONE; reset state is IDLE.
REQ-017 SHALL move IDLE->DONE on accepting a non-shift op, or a shift with k=0, giving 1-cycle latency.
REQ-018 SHALL move IDLE->SHIFT on accepting a shift with k>0, shifting one bit per cycle for k cycles, then SHIFT->DONE; latency k+1.
REQ-019 SHALL drive in_ready = (state==IDLE) | (state==DONE & out_ready), so an accept is possible on the same edge as a result hand-off.
REQ-020 SHALL drive out_valid=1 only in DONE, holding result, nzp and cout stable until out_ready=1.
REQ-021 SHALL move DONE->IDLE on out_ready without a new accept; on a same-cycle accept it SHALL go straight to DONE or SHIFT.
REQ-022 SHALL ignore in_valid in SHIFT.
REQ-023 SHALL set exactly one nzp bit from the signed result: N if negative, Z if zero, P otherwise.
REQ-024 SHALL set cout to the adder carry for ADD and to 0 for every other op.

Reset
REQ-025 SHALL, on Reset assertion at any time including mid-shift, asynchronously force state=IDLE, out_valid=0, result=0, nzp=3'b010, cout=0 and discard any in-flight op.
REQ-026 SHALL drive in_ready=1 in the first cycle after Reset deasserts.

Configuration
REQ-027 SHALL compile shift support only when EXEC_SHIFT_EN is defined.
REQ-028 SHALL, when EXEC_SHIFT_EN is undefined, remove the SHIFT state and shift datapath and treat ops 100-110 as PASS a with latency 1.

Structure
REQ-029 SHALL place the op enum, the FSM state enum and the NZP bit-index constants in shared package exec_pkg.
REQ-030 SHALL compute ADD with one sub-module, ripple_adder_n, parametrised by width, with carry out.

Verification
REQ-031 Bench SHALL check reset: Reset pulse mid-shift -> out_valid=0, nzp=010, in_ready=1 after release.
REQ-032 Bench SHALL check ADD: a=16'h7FFF, b=16'h0001 -> result=16'h8000, nzp=100, cout=0, out_valid one cycle after accept.
REQ-033 Bench SHALL check immediate ADD: a=16'h0003, use_imm=1, imm=5'b11101 (-3) -> result=16'h0000, nzp=010, cout=1.
REQ-034 Bench SHALL check SRA: a=16'h8000, b=4 -> result=16'hF800, out_valid exactly 5 cycles after accept.
REQ-035 Bench SHALL check back-pressure: out_ready=0 for 3 cycles on AND result 16'h00F0 -> result stable and in_ready=0 throughout.
REQ-036 Bench SHALL check back-to-back: out_ready=1 and in_valid=1 held in DONE -> one result per cycle for NOT a=16'h0000 then PASS a=16'h1234 (16'hFFFF, then 16'h1234).
